thread_msg_arbiter: RTL

- Shares the single dispatcher message channel (msg code + addr + data + pulse, done code back) between NUM_CPU per-core thread controllers.
- Each controller issues one-cycle fork/stop request pulses. The arbiter queues one request per port, grants round-robin, forwards it to the dispatcher, waits for the matching done code, then returns a one-cycle ack to the originating port.
- Sits between the core array and the thread dispatcher.

---
 rtl/thread_msg_arbiter_if.sv | 39 +++
 rtl/thread_msg_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/thread_msg_arbiter_if.sv
// Request/ack and dispatcher message bus shared by the thread controllers
// and the thread dispatcher through the thread message arbiter.
interface thread_msg_arbiter_if #(
  parameter int unsigned NUM_CPU = 4,
  parameter int unsigned MSG_W   = 8,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned ID_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

  logic [NUM_CPU-1:0]        req_pulse;
  logic [NUM_CPU*MSG_W-1:0]  req_msg;
  logic [NUM_CPU*ADDR_W-1:0] req_addr;
  logic [NUM_CPU*DATA_W-1:0] req_data;
  logic [NUM_CPU-1:0]        ack_pulse;
  logic [MSG_W-1:0]          ack_msg;
  logic                      disp_online;
  logic                      disp_pulse;
  logic [MSG_W-1:0]          disp_msg;
  logic [ADDR_W-1:0]         disp_addr;
  logic [DATA_W-1:0]         disp_data;
  logic [MSG_W-1:0]          disp_msg_in;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      overrun_err;
  logic                      timeout_err;

  modport master (
    output req_pulse, req_msg, req_addr, req_data, disp_online, disp_msg_in,
    input  ack_pulse, ack_msg, disp_pulse, disp_msg, disp_addr, disp_data,
           busy, grant_id, overrun_err, timeout_err
  );

  modport slave (
    input  req_pulse, req_msg, req_addr, req_data, disp_online, disp_msg_in,
    output ack_pulse, ack_msg, disp_pulse, disp_msg, disp_addr, disp_data,
           busy, grant_id, overrun_err, timeout_err
  );
endinterface

// File: rtl/thread_msg_arbiter.sv
// Round-robin arbiter sharing one dispatcher message channel between NUM_CPU
// thread controllers; one outstanding request, acked back to its origin port.
module thread_msg_arbiter #(
  parameter int unsigned      NUM_CPU       = 4,
  parameter int unsigned      MSG_W         = 8,
  parameter int unsigned      ADDR_W        = 32,
  parameter int unsigned      DATA_W        = 32,
  parameter logic [MSG_W-1:0] MSG_FORK      = MSG_W'(8'h01),
  parameter logic [MSG_W-1:0] MSG_STOP      = MSG_W'(8'h02),
  parameter logic [MSG_W-1:0] MSG_FORK_DONE = MSG_W'(8'h81),
  parameter logic [MSG_W-1:0] MSG_STOP_DONE = MSG_W'(8'h82),
  parameter int unsigned      TIMEOUT       = 255
) (
  input logic                 clk,
  input logic                 rst,
  thread_msg_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [NUM_CPU-1:0] pend_q, pend_d;
  logic [MSG_W-1:0]   msg_q  [NUM_CPU];
  logic [MSG_W-1:0]   msg_d  [NUM_CPU];
  logic [ADDR_W-1:0]  addr_q [NUM_CPU];
  logic [ADDR_W-1:0]  addr_d [NUM_CPU];
  logic [DATA_W-1:0]  data_q [NUM_CPU];
  logic [DATA_W-1:0]  data_d [NUM_CPU];
  logic [ID_W-1:0]    rr_q, rr_d, gid_q, gid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_CPU-1:0] ack_pulse_q, ack_pulse_d;
  logic [MSG_W-1:0]   ack_msg_q, ack_msg_d;
  logic               disp_pulse_q, disp_pulse_d;
  logic [MSG_W-1:0]   disp_msg_q, disp_msg_d;
  logic [ADDR_W-1:0]  disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0]  disp_data_q, disp_data_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;
  logic               tmo_q, tmo_d;

  logic [ID_W-1:0]    pick;
  logic [ID_W-1:0]    port;
  logic [MSG_W-1:0]   exp_done;
  logic [MSG_W-1:0]   code;

  // First pending port at or after the round-robin pointer, wrapping.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_CPU-1:0] pend,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick_v;
    logic            hit;
    int unsigned     idx;
    pick_v = ptr;
    hit    = 1'b0;
    for (int unsigned k = 0; k < NUM_CPU; k++) begin
      idx = (32'(ptr) + k) % NUM_CPU;
      if (!hit && pend[ID_W'(idx)]) begin
        hit    = 1'b1;
        pick_v = ID_W'(idx);
      end
    end
    return pick_v;
  endfunction

  assign pick     = rr_pick(pend_q, rr_q);
  assign exp_done = (msg_q[gid_q] == MSG_STOP) ? MSG_STOP_DONE : MSG_FORK_DONE;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    msg_d        = msg_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rr_d         = rr_q;
    gid_d        = gid_q;
    cnt_d        = cnt_q;
    ack_pulse_d  = '0;
    ack_msg_d    = '0;
    disp_pulse_d = 1'b0;
    disp_msg_d   = '0;
    disp_addr_d  = '0;
    disp_data_d  = '0;
    busy_d       = 1'b0;
    ovr_d        = 1'b0;
    tmo_d        = 1'b0;
    code         = '0;
    port         = '0;

    case (state_q)
      S_IDLE: begin
        if ((|pend_q) && bus.disp_online) begin
          state_d      = S_ISSUE;
          gid_d        = pick;
          disp_pulse_d = 1'b1;
          disp_msg_d   = msg_q[pick];
          disp_addr_d  = addr_q[pick];
          disp_data_d  = data_q[pick];
          busy_d       = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      S_WAIT: begin
        if (bus.disp_msg_in == exp_done) begin
          state_d            = S_ACK;
          ack_pulse_d[gid_q] = 1'b1;
          ack_msg_d          = exp_done;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d            = S_ACK;
          ack_pulse_d[gid_q] = 1'b1;
          tmo_d              = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      S_ACK: begin
        state_d       = S_IDLE;
        pend_d[gid_q] = 1'b0;
        rr_d          = (gid_q == ID_W'(NUM_CPU - 1)) ? '0 : gid_q + ID_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Capture sees the ACK clear first, so a slot freed this edge can refill.
    for (int unsigned i = 0; i < NUM_CPU; i++) begin
      port = ID_W'(i);
      code = bus.req_msg[i*MSG_W +: MSG_W];
      if (bus.req_pulse[port]) begin
        if (pend_d[port] || !((code == MSG_FORK) || (code == MSG_STOP))) begin
          ovr_d = 1'b1;
        end else begin
          pend_d[port] = 1'b1;
          msg_d[port]  = code;
          addr_d[port] = bus.req_addr[i*ADDR_W +: ADDR_W];
          data_d[port] = bus.req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      msg_q        <= '{default: '0};
      addr_q       <= '{default: '0};
      data_q       <= '{default: '0};
      rr_q         <= '0;
      gid_q        <= '0;
      cnt_q        <= '0;
      ack_pulse_q  <= '0;
      ack_msg_q    <= '0;
      disp_pulse_q <= 1'b0;
      disp_msg_q   <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      busy_q       <= 1'b0;
      ovr_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      msg_q        <= msg_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rr_q         <= rr_d;
      gid_q        <= gid_d;
      cnt_q        <= cnt_d;
      ack_pulse_q  <= ack_pulse_d;
      ack_msg_q    <= ack_msg_d;
      disp_pulse_q <= disp_pulse_d;
      disp_msg_q   <= disp_msg_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.ack_pulse   = ack_pulse_q;
  assign bus.ack_msg     = ack_msg_q;
  assign bus.disp_pulse  = disp_pulse_q;
  assign bus.disp_msg    = disp_msg_q;
  assign bus.disp_addr   = disp_addr_q;
  assign bus.disp_data   = disp_data_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = gid_q;
  assign bus.overrun_err = ovr_q;
  assign bus.timeout_err = tmo_q;
endmodule
